// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// pipeline_ctrl_pkg : shared stall bit positions, stall codes, FSM states
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

  localparam int STALL_W = 5;
  localparam int ADDR_W  = 32;

  localparam int STALL_PC    = 0;
  localparam int STALL_ID_EX = 2;

  localparam logic [STALL_W-1:0] STALL_NONE   = 5'b00000;
  localparam logic [STALL_W-1:0] STALL_BY_IF  = 5'b00011;
  localparam logic [STALL_W-1:0] STALL_BY_ID  = 5'b00111;
  localparam logic [STALL_W-1:0] STALL_BY_EX  = 5'b01111;
  localparam logic [STALL_W-1:0] STALL_BY_MEM = 5'b11111;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_FLUSH_WAIT = 2'd1,
    ST_FLUSH      = 2'd2
  } state_e;

  // The deepest requester holds everything upstream of it.
  function automatic logic [STALL_W-1:0] stall_encode(
    input logic s_if,
    input logic s_id,
    input logic s_ex,
    input logic s_mem
  );
    if (s_mem)      return STALL_BY_MEM;
    else if (s_ex)  return STALL_BY_EX;
    else if (s_id)  return STALL_BY_ID;
    else if (s_if)  return STALL_BY_IF;
    else            return STALL_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// ============================================================================
// stall_watchdog : consecutive-stall watchdog with sticky timeout, plus a
//                  saturating count of all PC-stalled cycles
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module stall_watchdog #(
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_pc,
  input  logic                 flush,
  output logic                 stall_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int              WD_W     = $clog2(WDOG_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WDOG_LIMIT);

  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!stall_pc || flush)
      wd_cnt_d = '0;
    else if (wd_cnt_q != WD_LIMIT)
      wd_cnt_d = wd_cnt_q + WD_W'(1);

    // Flag rises in the same cycle the limit-th consecutive stall is seen.
    timeout_d = timeout_q | (wd_cnt_d == WD_LIMIT);

    cycles_d = cycles_q;
    if (stall_pc && (cycles_q != '1))
      cycles_d = cycles_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
    end
  end

  assign stall_timeout = timeout_d;
  assign stall_cycles  = cycles_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// pipeline_ctrl : stall merge, exception flush sequencing and PC redirect
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int WDOG_LIMIT = 1024,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_from_if,
  input  logic                 stall_from_id,
  input  logic                 stall_from_ex,
  input  logic                 stall_from_mem,
  input  logic                 branch_flag,
  input  logic [ADDR_W-1:0]    branch_addr,
  input  logic                 exc_flag,
  input  logic [ADDR_W-1:0]    exc_pc,
  output logic [STALL_W-1:0]   stall,
  output logic                 flush,
  output logic                 pc_redirect_en,
  output logic [ADDR_W-1:0]    pc_redirect_addr,
  output logic                 stall_timeout,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  state_e              state_q, state_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0]   exc_pc_q, exc_pc_d;

  logic [STALL_W-1:0]  req_stall;
  logic [STALL_W-1:0]  stall_int;
  logic                flush_int;
  logic                redir_en_int;
  logic [ADDR_W-1:0]   redir_addr_int;
  logic                wd_timeout;
  logic [CNT_WIDTH-1:0] wd_cycles;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      exc_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      exc_pc_q     <= exc_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    exc_pc_d     = exc_pc_q;
    case (state_q)
      ST_RUN: begin
        if (pend_valid_q && !stall_int[STALL_PC]) begin
          pend_valid_d = 1'b0;
        end else if (branch_flag && stall_int[STALL_PC] && !stall_int[STALL_ID_EX]) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = branch_addr;
        end
        // While MEM is stalled the exception source keeps exc_flag asserted.
        if (exc_flag && !stall_from_mem) begin
          exc_pc_d = exc_pc;
          state_d  = stall_from_if ? ST_FLUSH_WAIT : ST_FLUSH;
        end
      end
      ST_FLUSH_WAIT: begin
        if (!stall_from_if)
          state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d      = ST_RUN;
        pend_valid_d = 1'b0;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    req_stall      = stall_encode(stall_from_if, stall_from_id, stall_from_ex, stall_from_mem);
    stall_int      = req_stall;
    flush_int      = 1'b0;
    redir_en_int   = 1'b0;
    redir_addr_int = '0;
    case (state_q)
      ST_FLUSH: begin
        stall_int      = STALL_NONE;
        flush_int      = 1'b1;
        redir_en_int   = 1'b1;
        redir_addr_int = exc_pc_q;
      end
      ST_FLUSH_WAIT: begin
        stall_int = req_stall | STALL_BY_IF;
      end
      default: begin
        if (pend_valid_q && !req_stall[STALL_PC]) begin
          redir_en_int   = 1'b1;
          redir_addr_int = pend_addr_q;
        end else if (branch_flag && !req_stall[STALL_PC]) begin
          redir_en_int   = 1'b1;
          redir_addr_int = branch_addr;
        end
      end
    endcase
  end

  stall_watchdog #(
    .WDOG_LIMIT (WDOG_LIMIT),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_stall_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stall_pc      (stall_int[STALL_PC]),
    .flush         (flush_int),
    .stall_timeout (wd_timeout),
    .stall_cycles  (wd_cycles)
  );

  assign stall            = rst ? stall_int      : '0;
  assign flush            = rst & flush_int;
  assign pc_redirect_en   = rst & redir_en_int;
  assign pc_redirect_addr = rst ? redir_addr_int : '0;
  assign stall_timeout    = rst & wd_timeout;
  assign stall_cycles     = rst ? wd_cycles      : '0;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// tb_pipeline_ctrl : directed vector table plus watchdog timing sequence
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_if, s_id, s_ex, s_mem;
  logic        br;
  logic [31:0] br_addr;
  logic        exc;
  logic [31:0] exc_pc;
  logic [4:0]  stall;
  logic        flush;
  logic        redir_en;
  logic [31:0] redir_addr;
  logic        timeout;
  logic [31:0] cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .WDOG_LIMIT (8),
    .CNT_WIDTH  (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_from_if    (s_if),
    .stall_from_id    (s_id),
    .stall_from_ex    (s_ex),
    .stall_from_mem   (s_mem),
    .branch_flag      (br),
    .branch_addr      (br_addr),
    .exc_flag         (exc),
    .exc_pc           (exc_pc),
    .stall            (stall),
    .flush            (flush),
    .pc_redirect_en   (redir_en),
    .pc_redirect_addr (redir_addr),
    .stall_timeout    (timeout),
    .stall_cycles     (cycles)
  );

  typedef struct {
    logic        rst, sif, sid, sex, smem, br;
    logic [31:0] baddr;
    logic        exc;
    logic [31:0] epc;
    logic [4:0]  e_stall;
    logic        e_flush, e_en;
    logic [31:0] e_addr;
    logic        e_to;
    logic [31:0] e_cyc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic sif, input logic sid, input logic sex,
                     input logic smem, input logic b, input logic [31:0] ba,
                     input logic ex, input logic [31:0] ep,
                     input logic [4:0] es, input logic ef, input logic een,
                     input logic [31:0] ea, input logic eto, input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.sif = sif; v.sid = sid; v.sex = sex; v.smem = smem; v.br = b;
    v.baddr = ba; v.exc = ex; v.epc = ep;
    v.e_stall = es; v.e_flush = ef; v.e_en = een; v.e_addr = ea; v.e_to = eto; v.e_cyc = ec;
    vq.push_back(v);
  endtask

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    s_if = 0; s_id = 0; s_ex = 0; s_mem = 0; br = 0; br_addr = '0; exc = 0; exc_pc = '0;
  endtask

  initial begin
    int seen;
    rst = 0;
    idle_inputs();

    //   rst if id ex mem br baddr         exc epc            stall    fl en addr          to cyc
    add(0, 0, 0, 0, 1, 1, 32'h0000_1234, 0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 0);  // 0
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 0);
    add(1, 0, 1, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00111, 0, 0, 32'h0,         0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 1);
    add(1, 0, 0, 0, 0, 1, 32'h0000_2000, 0, 32'h0,         5'b00000, 0, 1, 32'h0000_2000, 0, 1);  // 5
    add(1, 1, 0, 0, 0, 1, 32'h8000_0100, 0, 32'h0,         5'b00011, 0, 0, 32'h0,         0, 1);
    add(1, 1, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00011, 0, 0, 32'h0,         0, 2);
    add(1, 0, 0, 0, 0, 1, 32'h0000_3000, 0, 32'h0,         5'b00000, 0, 1, 32'h8000_0100, 0, 3);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 3);
    add(1, 0, 0, 1, 0, 1, 32'h0000_4000, 0, 32'h0,         5'b01111, 0, 0, 32'h0,         0, 3);  // 10
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 4);
    add(1, 0, 0, 0, 1, 0, 32'h0,         1, 32'hBFC0_0380, 5'b11111, 0, 0, 32'h0,         0, 4);
    add(1, 0, 0, 0, 1, 0, 32'h0,         1, 32'hBFC0_0380, 5'b11111, 0, 0, 32'h0,         0, 5);
    add(1, 0, 0, 0, 1, 0, 32'h0,         1, 32'hBFC0_0380, 5'b11111, 0, 0, 32'h0,         0, 6);
    add(1, 0, 0, 0, 0, 0, 32'h0,         1, 32'hBFC0_0380, 5'b00000, 0, 0, 32'h0,         0, 7);  // 15
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 1, 1, 32'hBFC0_0380, 0, 7);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 7);
    add(1, 1, 0, 0, 0, 1, 32'h8000_0200, 0, 32'h0,         5'b00011, 0, 0, 32'h0,         0, 7);
    add(1, 1, 0, 0, 0, 0, 32'h0,         1, 32'h0000_0180, 5'b00011, 0, 0, 32'h0,         0, 8);
    add(1, 1, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00011, 0, 0, 32'h0,         0, 9);  // 20
    add(1, 1, 0, 0, 0, 1, 32'h0000_5000, 0, 32'h0,         5'b00011, 0, 0, 32'h0,         0, 10);
    add(1, 1, 1, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00111, 0, 0, 32'h0,         0, 11);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00011, 0, 0, 32'h0,         0, 12);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 1, 1, 32'h0000_0180, 0, 13);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 13); // 25
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 1, 0, 0, 32'h0, 0, 32'h0, 5'b01111, 0, 0, 32'h0, (i == 7), 32'(13 + i));       // 26..33
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         1, 21);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 0);
    add(1, 1, 0, 0, 0, 1, 32'h8000_0300, 0, 32'h0,         5'b00011, 0, 0, 32'h0,         0, 0);
    add(1, 1, 0, 0, 0, 0, 32'h0,         1, 32'h0000_9000, 5'b00011, 0, 0, 32'h0,         0, 1);
    add(1, 1, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00011, 0, 0, 32'h0,         0, 2);  // 39
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 0);
    add(1, 0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         5'b00000, 0, 0, 32'h0,         0, 0);

    @(posedge clk); #1;
    foreach (vq[k]) begin
      bit ok;
      rst = vq[k].rst; s_if = vq[k].sif; s_id = vq[k].sid; s_ex = vq[k].sex; s_mem = vq[k].smem;
      br = vq[k].br; br_addr = vq[k].baddr; exc = vq[k].exc; exc_pc = vq[k].epc;
      @(negedge clk);
      ok = (stall === vq[k].e_stall) && (flush === vq[k].e_flush) && (redir_en === vq[k].e_en) &&
           (!vq[k].e_en || (redir_addr === vq[k].e_addr)) && (timeout === vq[k].e_to) &&
           (cycles === vq[k].e_cyc);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d: got stall=%b flush=%b en=%b addr=%h to=%b cyc=%0d, want stall=%b flush=%b en=%b addr=%h to=%b cyc=%0d",
                 k, stall, flush, redir_en, redir_addr, timeout, cycles,
                 vq[k].e_stall, vq[k].e_flush, vq[k].e_en, vq[k].e_addr, vq[k].e_to, vq[k].e_cyc);
      end
      @(posedge clk); #1;
    end

    // Watchdog: first cycle the flag is seen under a continuous EX stall.
    rst = 0; idle_inputs();
    @(posedge clk); #1;
    rst = 1; s_ex = 1; seen = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        seen = n;
        break;
      end
      @(posedge clk); #1;
    end
    check(seen == 8, "wdog_first_cycle", 32'(seen), 32'd8);
    @(posedge clk); #1;
    s_ex = 0;
    @(negedge clk);
    check(timeout === 1'b1, "wdog_sticky", {31'd0, timeout}, 32'd1);
    check(cycles === 32'd8, "wdog_stall_cycles", cycles, 32'd8);
    check(stall === 5'b00000, "wdog_release_stall", {27'd0, stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
